// File: rtl/hex_display_scanner_pkg.sv
// Shared display definitions for the multiplexed hex scanner: FSM states,
// blank/off constants and the captured display configuration.
package hex_display_scanner_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } scan_state_e;

    localparam logic [6:0] BLANK_SEG = 7'b1111111;
    localparam logic [3:0] ALL_OFF   = 4'b1111;

    typedef struct packed {
        logic [15:0] value;
        logic        lzBlank;
        logic [3:0]  blinkMask;
    } disp_cfg_t;

    // Bit i set when digit i sits above the most significant nonzero digit;
    // digit 0 is never marked so a zero value still shows one "0".
    function automatic logic [3:0] lzBlankMask(input logic [15:0] v);
        logic [3:0] mask;
        logic       seenNonzero;
        mask        = 4'b0000;
        seenNonzero = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            if (v[i*4 +: 4] != 4'h0) begin
                seenNonzero = 1'b1;
            end
            mask[i] = ~seenNonzero;
        end
        return mask;
    endfunction

endpackage

// File: rtl/hex_display_scanner_sevenseg.sv
// Hex nibble to active-low seven-segment glyph, bit order {g,f,e,d,c,b,a}.
module SevenSegment (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Four-digit multiplexed hex display scanner with anti-ghost gaps, leading-zero
// blanking, per-digit blink and frame-aligned (tear-free) value updates.
module hex_display_scanner
    import hex_display_scanner_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int GAP_CYCLES   = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        lz_blank,
    input  logic [3:0]  blink_mask,
    output logic        ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_start
);

    localparam int MAXC = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int BW   = $clog2(BLINK_FRAMES) + 1;

    scan_state_e    state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     digit_q, digit_d;
    logic [BW-1:0]  frameCnt_q, frameCnt_d;
    logic           blink_q, blink_d;
    disp_cfg_t      active_q, active_d;
    disp_cfg_t      shadow_q, shadow_d;
    logic           pending_q, pending_d;
    logic [3:0]     an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic           frameStart_q, frameStart_d;

    logic           accept;
    disp_cfg_t      cfgIn;
    logic [3:0]     nibble;
    logic [6:0]     glyph;
    logic [3:0]     lzMask;
    logic           blankDigit;

    assign ready  = ~pending_q;
    assign accept = load & ~pending_q;
    assign cfgIn  = '{value: value, lzBlank: lz_blank, blinkMask: blink_mask};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        digit_d    = digit_q;
        frameCnt_d = frameCnt_q;
        blink_d    = blink_q;
        active_d   = active_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;

        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (accept) begin
                    active_d = cfgIn;
                    state_d  = ST_DRIVE;
                    digit_d  = 2'd0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CW'(DIGIT_CYCLES - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                    // End of the digit-3 gap is the frame boundary: swap in
                    // any pending value and advance the blink timer.
                    if (digit_q == 2'd3) begin
                        if (pending_q) begin
                            active_d  = shadow_q;
                            pending_d = 1'b0;
                        end
                        if (frameCnt_q == BW'(BLINK_FRAMES - 1)) begin
                            frameCnt_d = '0;
                            blink_d    = ~blink_q;
                        end else begin
                            frameCnt_d = frameCnt_q + BW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        if (accept && state_q != ST_OFF) begin
            shadow_d  = cfgIn;
            pending_d = 1'b1;
        end
    end

    // Outputs are registered from next-state values so an and seg move together.
    always_comb begin
        nibble = active_d.value[3:0];
        case (digit_d)
            2'd0: nibble = active_d.value[3:0];
            2'd1: nibble = active_d.value[7:4];
            2'd2: nibble = active_d.value[11:8];
            2'd3: nibble = active_d.value[15:12];
            default: nibble = active_d.value[3:0];
        endcase
    end

    SevenSegment u_decoder (
        .hex_i (nibble),
        .seg_o (glyph)
    );

    always_comb begin
        lzMask       = lzBlankMask(active_d.value);
        blankDigit   = (active_d.lzBlank && lzMask[digit_d]) ||
                       (blink_d && active_d.blinkMask[digit_d]);
        an_d         = ALL_OFF;
        seg_d        = BLANK_SEG;
        frameStart_d = 1'b0;
        if (state_d == ST_DRIVE) begin
            an_d         = ~(4'b0001 << digit_d);
            seg_d        = blankDigit ? BLANK_SEG : glyph;
            frameStart_d = (state_q != ST_DRIVE) && (digit_d == 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            frameCnt_q   <= '0;
            blink_q      <= 1'b0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= ALL_OFF;
            seg_q        <= BLANK_SEG;
            frameStart_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            frameCnt_q   <= frameCnt_d;
            blink_q      <= blink_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_start = frameStart_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner with short scan timing
// (4 drive cycles, 1 gap cycle, blink every 2 frames => 20-cycle frames).
module tb_hex_display_scanner;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
        logic       rdy;
    } exp_t;

    typedef struct packed {
        logic [15:0] v;
        logic        lz;
        logic [3:0]  m;
    } cfg_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        lz_blank = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic        ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_start;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    hex_display_scanner #(
        .DIGIT_CYCLES (4),
        .GAP_CYCLES   (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .lz_blank    (lz_blank),
        .blink_mask  (blink_mask),
        .ready       (ready),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    function automatic logic [6:0] glyphOf(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Expected outputs t cycles after the first display cycle; cfg b takes
    // over at the frame following acceptT (acceptT < 0 means no update).
    function automatic exp_t model(input int t, input cfg_t a, input cfg_t b, input int acceptT);
        exp_t e;
        cfg_t c;
        int   p, f, d, msd;
        logic blank;
        logic [3:0] nib;
        p = t % 20;
        f = t / 20;
        d = (p / 5);
        c = (acceptT >= 0 && f > acceptT / 20) ? b : a;
        e.rdy = !(acceptT >= 0 && t > acceptT && t < (acceptT / 20 + 1) * 20);
        e.fs  = (p == 0);
        if (p % 5 == 4) begin
            e.an  = 4'b1111;
            e.seg = 7'b1111111;
        end else begin
            e.an = 4'b1111;
            e.an[d] = 1'b0;
            msd = 0;
            for (int i = 0; i < 4; i++) if (c.v[i*4 +: 4] != 4'h0) msd = i;
            blank = (c.lz && d > msd) || (c.m[d] && ((f / 2) % 2 == 1));
            nib = c.v[d*4 +: 4];
            e.seg = blank ? 7'b1111111 : glyphOf(nib);
        end
        return e;
    endfunction

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic startLoad(input cfg_t c);
        load       = 1'b1;
        value      = c.v;
        lz_blank   = c.lz;
        blink_mask = c.m;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        exp_t got;
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b1;
        value = 16'h1234;
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            got = {an, seg, frame_start, ready};
            checks++;
            if (got !== {4'b1111, 7'b1111111, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_off i=%0d got=%b exp=%b", i, got, {4'b1111, 7'b1111111, 1'b0, 1'b1});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        exp_t e, got;
        cfg_t a = '{16'h1234, 1'b0, 4'b0000};
        doReset();
        startLoad(a);
        for (int t = 0; t < 40; t++) sb.push_back(model(t, a, a, -1));
        for (int t = 0; t < 40; t++) begin
            e   = sb.pop_front();
            got = {an, seg, frame_start, ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL basic t=%0d got=%b exp=%b", t, got, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_midframe_update();
        exp_t e, got;
        cfg_t a = '{16'h1234, 1'b0, 4'b0000};
        cfg_t b = '{16'hABCD, 1'b0, 4'b0000};
        doReset();
        startLoad(a);
        for (int t = 0; t < 40; t++) sb.push_back(model(t, a, b, 7));
        for (int t = 0; t < 40; t++) begin
            e   = sb.pop_front();
            got = {an, seg, frame_start, ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL midframe t=%0d got=%b exp=%b", t, got, e);
            end
            load  = (t == 7) || (t == 10);
            value = (t == 10) ? 16'hFFFF : 16'hABCD;
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic test_lz_blank();
        exp_t e, got;
        cfg_t a = '{16'h0050, 1'b1, 4'b0000};
        cfg_t b = '{16'h0000, 1'b1, 4'b0000};
        doReset();
        startLoad(a);
        for (int t = 0; t < 60; t++) sb.push_back(model(t, a, b, 25));
        for (int t = 0; t < 60; t++) begin
            e   = sb.pop_front();
            got = {an, seg, frame_start, ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL lz_blank t=%0d got=%b exp=%b", t, got, e);
            end
            load     = (t == 25);
            value    = b.v;
            lz_blank = 1'b1;
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic test_blink();
        exp_t e, got;
        cfg_t a = '{16'h1111, 1'b0, 4'b0001};
        doReset();
        startLoad(a);
        for (int t = 0; t < 100; t++) sb.push_back(model(t, a, a, -1));
        for (int t = 0; t < 100; t++) begin
            e   = sb.pop_front();
            got = {an, seg, frame_start, ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL blink t=%0d got=%b exp=%b", t, got, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_pending();
        exp_t e, got;
        cfg_t a = '{16'h1234, 1'b0, 4'b0000};
        cfg_t b = '{16'h5678, 1'b0, 4'b0000};
        cfg_t c = '{16'h9999, 1'b0, 4'b0000};
        doReset();
        startLoad(a);
        for (int t = 0; t < 15; t++) sb.push_back(model(t, a, b, 7));
        for (int t = 0; t < 15; t++) begin
            e   = sb.pop_front();
            got = {an, seg, frame_start, ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pend_pre t=%0d got=%b exp=%b", t, got, e);
            end
            load  = (t == 7);
            value = b.v;
            reset = (t == 14);
            @(negedge clk);
        end
        reset = 1'b0;
        load  = 1'b0;
        for (int i = 0; i < 20; i++) sb.push_back({4'b1111, 7'b1111111, 1'b0, 1'b1});
        for (int i = 0; i < 20; i++) begin
            e   = sb.pop_front();
            got = {an, seg, frame_start, ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pend_off i=%0d got=%b exp=%b", i, got, e);
            end
            @(negedge clk);
        end
        startLoad(c);
        for (int t = 0; t < 20; t++) sb.push_back(model(t, c, c, -1));
        for (int t = 0; t < 20; t++) begin
            e   = sb.pop_front();
            got = {an, seg, frame_start, ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pend_post t=%0d got=%b exp=%b", t, got, e);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_midframe_update();
        test_lz_blank();
        test_blink();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
